// File: rtl/knight_cmd_link.sv
// rtl/knight_cmd_link.sv - UART command link: two-byte command receiver plus response-byte transmitter
//
// Purpose:
//   Receives 8N1 UART bytes on RX and pairs them into 16-bit commands
//   {first byte, second byte}. Independently transmits a single response
//   byte on TX when the command processor pulses trmt. RX and TX paths share
//   no state, so the link runs full duplex.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   RX           UART serial input, idle high, asynchronous to clk
//   TX           UART serial output, idle high
//   cmd          last completed command {high byte, low byte}
//   cmd_rdy      high while cmd holds an unconsumed command
//   clr_cmd_rdy  one-cycle pulse consuming cmd
//   trmt         one-cycle pulse requesting transmission of resp
//   resp         response byte, sampled on the trmt cycle
//   tx_done      high after a byte completes, low from the next accepted trmt

module knight_cmd_link #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  // The counter expires on the cycle it reads 0, so reloading with
  // BAUD_DIV-1 gives exactly BAUD_DIV clocks between samples/bit edges.
  localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [0:0] AS_WAIT_HI = 1'b0;
  localparam logic [0:0] AS_WAIT_LO = 1'b1;

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_TXING = 1'b1;

  // ---------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------
  logic        rx_meta;
  logic        rx_sync;
  logic [1:0]  rx_state;
  logic [11:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_byte;   // one-cycle strobe: rx_shift holds a good byte
  logic        rx_ferr;   // one-cycle strobe: stop bit was 0

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 12'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_byte  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      // Preset-to-1 synchronizer keeps a released reset from looking like a start bit.
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_byte <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= BAUD_HALF;
          end
        end
        RX_START: begin
          if (rx_cnt == 12'd0) begin
            // Still low at mid start bit: real frame; otherwise a glitch.
            if (!rx_sync) begin
              rx_state <= RX_DATA;
              rx_cnt   <= BAUD_FULL;
              rx_bit   <= 3'd0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 12'd0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= BAUD_FULL;
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 12'd0) begin
            if (rx_sync) begin
              rx_byte <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Command assembly
  // ---------------------------------------------------------------------
  logic [0:0] as_state;
  logic [7:0] as_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_state <= AS_WAIT_HI;
      as_hi    <= 8'd0;
      cmd      <= 16'h0000;
      cmd_rdy  <= 1'b0;
    end else begin
      // Later assignments below override this, so a completing command
      // beats a simultaneous clear.
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      if (rx_byte) begin
        if (as_state == AS_WAIT_HI) begin
          as_hi    <= rx_shift;
          cmd_rdy  <= 1'b0;
          as_state <= AS_WAIT_LO;
        end else begin
          cmd      <= {as_hi, rx_shift};
          cmd_rdy  <= 1'b1;
          as_state <= AS_WAIT_HI;
        end
      end else if (rx_ferr) begin
        // Resynchronize on a bad frame; the published command is untouched.
        as_state <= AS_WAIT_HI;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------
  logic [0:0]  tx_state;
  logic [9:0]  tx_shift;  // bit 0 drives the line; refills with 1s (idle/stop)
  logic [11:0] tx_cnt;
  logic [3:0]  tx_bit;

  assign TX = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= 10'h3FF;
      tx_cnt   <= 12'd0;
      tx_bit   <= 4'd0;
      tx_done  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (trmt) begin
            tx_shift <= {1'b1, resp, 1'b0};
            tx_cnt   <= BAUD_FULL;
            tx_bit   <= 4'd0;
            tx_done  <= 1'b0;
            tx_state <= TX_TXING;
          end
        end
        TX_TXING: begin
          // trmt is deliberately not looked at here: the frame in flight is never disturbed.
          if (tx_cnt == 12'd0) begin
            if (tx_bit == 4'd9) begin
              tx_state <= TX_IDLE;
              tx_done  <= 1'b1;
              tx_shift <= 10'h3FF;
            end else begin
              tx_shift <= {1'b1, tx_shift[9:1]};
              tx_bit   <= tx_bit + 4'd1;
              tx_cnt   <= BAUD_FULL;
            end
          end else begin
            tx_cnt <= tx_cnt - 12'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
